sram64_port_arbiter: RTL

// Shares one 64-bit single-port SRAM-style slave (ena/wea/addra/dina/douta, fixed read

---
 rtl/sram64_port_arbiter.sv | 103 ++++++++++
 1 files changed

// File: rtl/sram64_port_arbiter.sv
// Two-port round-robin arbiter in front of a single-port fixed-latency SRAM slave.
// Responses are steered back to the issuing port through a latency-matched tag pipe.
module sram64_port_arbiter #(
  parameter int READ_LATENCY = 1,
  parameter int ADDR_W       = 64
) (
  input  logic              clka,
  input  logic              rstn,
  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [63:0]       m0_wdata,
  input  logic [7:0]        m0_wstrb,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [63:0]       m0_rdata,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [63:0]       m1_wdata,
  input  logic [7:0]        m1_wstrb,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [63:0]       m1_rdata,
  output logic              ena,
  output logic [7:0]        wea,
  output logic [ADDR_W-1:0] addra,
  output logic [63:0]       dina,
  input  logic [63:0]       douta
);

  // prio_q: 0 favours port 0, 1 favours port 1 when both request
  logic                    prio_q, prio_d;
  logic [READ_LATENCY-1:0] vld_q, vld_d;
  logic [READ_LATENCY-1:0] own_q, own_d;
  logic                    rsp_valid;

  // Grant selection, slave issue mux and pointer update
  always_comb begin
    m0_gnt = rstn & m0_req & (~m1_req | ~prio_q);
    m1_gnt = rstn & m1_req & (~m0_req | prio_q);
    if (m0_gnt) begin
      ena    = 1'b1;
      wea    = m0_wstrb;
      addra  = m0_addr;
      dina   = m0_wdata;
      prio_d = 1'b1;
    end else if (m1_gnt) begin
      ena    = 1'b1;
      wea    = m1_wstrb;
      addra  = m1_addr;
      dina   = m1_wdata;
      prio_d = 1'b0;
    end else begin
      ena    = 1'b0;
      wea    = 8'h00;
      addra  = {ADDR_W{1'b0}};
      dina   = 64'd0;
      prio_d = prio_q;
    end
  end

  // Response tag pipe: stage 0 captures this cycle's accept and its owner
  always_comb begin
    vld_d    = vld_q;
    own_d    = own_q;
    vld_d[0] = m0_gnt | m1_gnt;
    own_d[0] = m1_gnt;
    for (int i = 1; i < READ_LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      own_d[i] = own_q[i-1];
    end
  end

  // Last pipe stage lines up with douta; gated by rstn so nothing leaks during reset
  always_comb begin
    rsp_valid = rstn & vld_q[READ_LATENCY-1];
    m0_rvalid = rsp_valid & ~own_q[READ_LATENCY-1];
    m1_rvalid = rsp_valid &  own_q[READ_LATENCY-1];
    if (m0_rvalid) begin
      m0_rdata = douta;
    end else begin
      m0_rdata = 64'd0;
    end
    if (m1_rvalid) begin
      m1_rdata = douta;
    end else begin
      m1_rdata = 64'd0;
    end
  end

  // State registers; reset discards every in-flight response
  always_ff @(posedge clka) begin
    if (!rstn) begin
      prio_q <= 1'b0;
      vld_q  <= {READ_LATENCY{1'b0}};
      own_q  <= {READ_LATENCY{1'b0}};
    end else begin
      prio_q <= prio_d;
      vld_q  <= vld_d;
      own_q  <= own_d;
    end
  end

endmodule
